// File: rtl/uart_fifo_pkg.sv
// Shared defaults and op encoding for the second-generation UART buffer FIFO.
package uart_fifo_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_AE_LEVEL = 1;

    // Bit 1 = accepted write, bit 0 = accepted read.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/uart_fifo_ram.sv
// Register-array storage for uart_fifo_gen2.
// Synchronous write, asynchronous read.
module uart_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/uart_fifo_gen2.sv
// Show-ahead UART buffer FIFO with count, watermarks and sticky error flags.
// Define UART_FIFO_FLUSH_EN to enable the synchronous flush input.
module uart_fifo_gen2
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int AF_LEVEL = (1 << ADDR_W) - 2,
    parameter int AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              wr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              rd,
    input  logic              flush,
    input  logic              err_clr,
    output logic [DATA_W-1:0] r_data,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AF_CNT    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0]   AE_CNT    = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0]   ONE_CNT   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_PTR   = ADDR_W'(1);
    localparam logic              AF_RST    = (AF_LEVEL == 0);

    if (!(AE_LEVEL >= 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH))
    begin : g_bad_levels
        $error("uart_fifo_gen2: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [ADDR_W-1:0] w_ptr, r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt, r_ptr_nxt;
    logic [ADDR_W:0]   count_nxt;
    logic              do_rd, do_wr;
    logic              flush_act;
    fifo_op_e          op;

`ifdef UART_FIFO_FLUSH_EN
    assign flush_act = flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_act    = 1'b0;
`endif

    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | rd);
    assign op    = fifo_op_e'({do_wr, do_rd});

    always_comb begin
        w_ptr_nxt = w_ptr;
        r_ptr_nxt = r_ptr;
        count_nxt = count;
        unique case (op)
            OP_WR: begin
                w_ptr_nxt = w_ptr + ONE_PTR;
                count_nxt = count + ONE_CNT;
            end
            OP_RD: begin
                r_ptr_nxt = r_ptr + ONE_PTR;
                count_nxt = count - ONE_CNT;
            end
            OP_RW: begin
                w_ptr_nxt = w_ptr + ONE_PTR;
                r_ptr_nxt = r_ptr + ONE_PTR;
            end
            default: ;
        endcase
    end

    // Flags are registered from the next count so they line up with count.
    always_ff @(posedge clk) begin
        if (Reset) begin
            w_ptr        <= '0;
            r_ptr        <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= AF_RST;
            almost_empty <= 1'b1;
        end else if (flush_act) begin
            r_ptr        <= w_ptr;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= AF_RST;
            almost_empty <= 1'b1;
        end else begin
            w_ptr        <= w_ptr_nxt;
            r_ptr        <= r_ptr_nxt;
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_CNT);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_CNT);
            almost_empty <= (count_nxt <= AE_CNT);
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (Reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr & full & ~rd) | (overflow & ~err_clr);
            underflow <= (rd & empty) | (underflow & ~err_clr);
        end
    end

    uart_fifo_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk   (clk),
        .w_en  (do_wr & ~flush_act),
        .w_addr(w_ptr),
        .w_data(w_data),
        .r_addr(r_ptr),
        .r_data(r_data)
    );

endmodule

// File: tb/tb_uart_fifo_gen2.sv
// Directed self-checking bench for uart_fifo_gen2 (16 x 8, AF=14, AE=1).
module tb_uart_fifo_gen2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       rd = 1'b0;
    logic       flush = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] r_data;
    logic       full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;

    int checks = 0;
    int errors = 0;

    uart_fifo_gen2 #(
        .DATA_W(8),
        .ADDR_W(4),
        .AF_LEVEL(14),
        .AE_LEVEL(1)
    ) dut (
        .clk(clk),
        .Reset(rst),
        .wr(wr),
        .w_data(w_data),
        .rd(rd),
        .flush(flush),
        .err_clr(err_clr),
        .r_data(r_data),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr = 1'b0;
        rd = 1'b0;
        flush = 1'b0;
        err_clr = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({count, empty, full, almost_empty, almost_full, overflow, underflow}
            !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b expected cnt=0 e=1 f=0 ae=1 af=0 ov=0 un=0",
                     count, empty, full, almost_empty, almost_full, overflow, underflow);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1;
            w_data = 8'h11 + 8'(i);
            tick();
            checks++;
            if ({count, empty, full, almost_empty, almost_full}
                !== {5'(i + 1), 1'b0, (i == 15), (i == 0), (i >= 13)}) begin
                errors++;
                $display("FAIL fill_%0d: got cnt=%0d e=%b f=%b ae=%b af=%b expected cnt=%0d e=0 f=%b ae=%b af=%b",
                         i, count, empty, full, almost_empty, almost_full,
                         i + 1, (i == 15), (i == 0), (i >= 13));
            end
        end
        w_data = 8'h99;
        tick();
        wr = 1'b0;
        checks++;
        if ({count, full, overflow, r_data} !== {5'd16, 1'b1, 1'b1, 8'h11}) begin
            errors++;
            $display("FAIL overflow_write: got cnt=%0d f=%b ov=%b head=%h expected cnt=16 f=1 ov=1 head=11",
                     count, full, overflow, r_data);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (r_data !== 8'h11 + 8'(i)) begin
                errors++;
                $display("FAIL drain_data_%0d: got %h expected %h", i, r_data, 8'h11 + 8'(i));
            end
            rd = 1'b1;
            tick();
        end
        checks++;
        if ({count, empty, full, underflow} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL drain_empty: got cnt=%0d e=%b f=%b un=%b expected cnt=0 e=1 f=0 un=0",
                     count, empty, full, underflow);
        end
        tick();
        rd = 1'b0;
        checks++;
        if ({count, underflow, overflow} !== {5'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL underflow_read: got cnt=%0d un=%b ov=%b expected cnt=0 un=1 ov=1",
                     count, underflow, overflow);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if ({overflow, underflow} !== 2'b00) begin
            errors++;
            $display("FAIL err_clr_both: got ov=%b un=%b expected ov=0 un=0", overflow, underflow);
        end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1;
            w_data = 8'h30 + 8'(i);
            tick();
        end
        rd = 1'b1;
        w_data = 8'hAA;
        tick();
        wr = 1'b0;
        rd = 1'b0;
        checks++;
        if ({count, full, overflow, r_data} !== {5'd16, 1'b1, 1'b0, 8'h31}) begin
            errors++;
            $display("FAIL full_rw: got cnt=%0d f=%b ov=%b head=%h expected cnt=16 f=1 ov=0 head=31",
                     count, full, overflow, r_data);
        end
        for (int i = 0; i < 15; i++) begin
            rd = 1'b1;
            tick();
        end
        rd = 1'b0;
        checks++;
        if ({count, r_data} !== {5'd1, 8'hAA}) begin
            errors++;
            $display("FAIL full_rw_last: got cnt=%0d head=%h expected cnt=1 head=aa", count, r_data);
        end
        rd = 1'b1;
        tick();
        rd = 1'b0;
        checks++;
        if ({count, empty, underflow} !== {5'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL full_rw_drain: got cnt=%0d e=%b un=%b expected cnt=0 e=1 un=0",
                     count, empty, underflow);
        end
    endtask

    task automatic test_empty_rw();
        wr = 1'b1;
        rd = 1'b1;
        w_data = 8'h55;
        tick();
        wr = 1'b0;
        rd = 1'b0;
        checks++;
        if ({count, empty, almost_empty, r_data, underflow}
            !== {5'd1, 1'b0, 1'b1, 8'h55, 1'b1}) begin
            errors++;
            $display("FAIL empty_rw: got cnt=%0d e=%b ae=%b head=%h un=%b expected cnt=1 e=0 ae=1 head=55 un=1",
                     count, empty, almost_empty, r_data, underflow);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if ({underflow, count} !== {1'b0, 5'd1}) begin
            errors++;
            $display("FAIL err_clr_underflow: got un=%b cnt=%0d expected un=0 cnt=1", underflow, count);
        end
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] nxt;
        nxt = 8'h40;
        for (int i = 0; i < 3; i++) begin
            wr = 1'b1;
            w_data = nxt;
            q.push_back(nxt);
            nxt++;
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            checks++;
            if (r_data !== q[0]) begin
                errors++;
                $display("FAIL b2b_head_%0d: got %h expected %h", k, r_data, q[0]);
            end
            wr = 1'b1;
            rd = 1'b1;
            w_data = nxt;
            q.push_back(nxt);
            void'(q.pop_front());
            nxt++;
            tick();
            checks++;
            if (count !== 5'd3) begin
                errors++;
                $display("FAIL b2b_count_%0d: got %0d expected 3", k, count);
            end
        end
        rst = 1'b1;
        tick();
        idle();
        checks++;
        if ({count, empty, full, almost_empty, almost_full, overflow, underflow}
            !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b expected cnt=0 e=1 f=0 ae=1 af=0 ov=0 un=0",
                     count, empty, full, almost_empty, almost_full, overflow, underflow);
        end
    endtask

`ifdef UART_FIFO_FLUSH_EN
    task automatic test_flush();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr = 1'b1;
            w_data = 8'h60 + 8'(i);
            tick();
        end
        flush = 1'b1;
        w_data = 8'h77;
        tick();
        idle();
        checks++;
        if ({count, empty, almost_empty, underflow, overflow}
            !== {5'd0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL flush: got cnt=%0d e=%b ae=%b un=%b ov=%b expected cnt=0 e=1 ae=1 un=1 ov=0",
                     count, empty, almost_empty, underflow, overflow);
        end
        tick();
        checks++;
        if ({count, empty} !== {5'd0, 1'b1}) begin
            errors++;
            $display("FAIL flush_drop: got cnt=%0d e=%b expected cnt=0 e=1", count, empty);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_rw();
        test_empty_rw();
        test_back_to_back();
`ifdef UART_FIFO_FLUSH_EN
        test_flush();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
